// File: rtl/uart_word_loader_if.sv
// -----------------------------------------------------------------------------
// uart_word_loader_if
//   Memory write port between the UART word loader and the block RAM I/O port.
//
//   Signals:
//     addr_io     [15:0]  write address
//     data_in_io  [15:0]  write data
//     we_io               one-cycle write strobe
//
//   Modports:
//     master  - the loader (drives the port)
//     slave   - the memory (observes the port)
// -----------------------------------------------------------------------------
interface uart_word_loader_if;
    logic [15:0] addr_io;
    logic [15:0] data_in_io;
    logic        we_io;

    modport master (
        output addr_io,
        output data_in_io,
        output we_io
    );

    modport slave (
        input addr_io,
        input data_in_io,
        input we_io
    );
endinterface

// File: rtl/uart_word_loader.sv
// -----------------------------------------------------------------------------
// uart_word_loader
//   UART (8N1) receive-and-load stage in front of the processor's block RAM.
//   Received bytes are paired high-byte-first into 16-bit words and written to
//   consecutive addresses while the load switch (load_en) is high.
//
//   Parameters:
//     CLKS_PER_BIT  clk_100 cycles per UART bit (>= 4); 868 = 115200 baud @ 100 MHz
//     BASE_ADDR     first write address of every load session
//
//   Ports:
//     clk_100     in   system clock, rising edge
//     rst_n       in   asynchronous active-low reset
//     rx          in   UART line (idle high, asynchronous)
//     load_en     in   load session enable; a rising edge opens a new session
//     mem         if   memory write port (addr_io / data_in_io / we_io)
//     led_rx      out  high while a frame is being received
//     word_count  out  words written this session (saturates at 16'hFFFF)
//     frame_err   out  sticky: a stop bit was sampled low this session
//     load_done   out  session complete
//
//   Build option:
//     LOADER_END_MARKER_EN  when defined, an assembled word 16'hFFFF ends the
//                           session (load_done set, word not written, further
//                           bytes ignored). When undefined, 16'hFFFF is an
//                           ordinary word and load_done follows the falling
//                           edge of load_en.
// -----------------------------------------------------------------------------
module uart_word_loader #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [15:0] BASE_ADDR    = 16'h0000
) (
    input  logic                      clk_100,
    input  logic                      rst_n,
    input  logic                      rx,
    input  logic                      load_en,
    uart_word_loader_if.master        mem,
    output logic                      led_rx,
    output logic [15:0]               word_count,
    output logic                      frame_err,
    output logic                      load_done
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } rx_state_t;

    rx_state_t         state;
    rx_state_t         state_nxt;

    // rx_p0/rx_p1 form the synchroniser; rx_p2 is the previous synchronised
    // value, used only for start-edge detection.
    logic              rx_p0;
    logic              rx_p1;
    logic              rx_p2;
    logic              rx_fall;

    logic [CNT_W-1:0]  clk_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shreg;

    logic              half_tick;
    logic              bit_tick;
    logic              stop_ok;
    logic              stop_bad;

    logic              load_en_q;
    logic              load_rise;
`ifndef LOADER_END_MARKER_EN
    logic              load_fall;
`endif
    logic              pending;
    logic [15:0]       addr_q;
    logic [15:0]       data_q;
    logic              we_q;
    logic [15:0]       word_nxt;

    // ---- input synchroniser -------------------------------------------------
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
            rx_p2 <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_p1 <= rx_p0;
            rx_p2 <= rx_p1;
        end
    end

    assign rx_fall = rx_p2 & ~rx_p1;

    // ---- receiver FSM: state register ---------------------------------------
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---- receiver FSM: next state -------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (rx_fall) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (half_tick) begin
                    state_nxt = rx_p1 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (bit_tick && (bit_idx == 3'd7)) begin
                    state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                // Leave straight after the mid stop-bit sample so the next
                // start edge can be caught even with a slightly fast sender.
                if (bit_tick) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---- receiver FSM: outputs ----------------------------------------------
    always_comb begin
        led_rx    = 1'b0;
        half_tick = 1'b0;
        bit_tick  = 1'b0;
        stop_ok   = 1'b0;
        stop_bad  = 1'b0;
        unique case (state)
            S_IDLE: begin
                led_rx = 1'b0;
            end
            S_START: begin
                led_rx    = 1'b1;
                half_tick = (clk_cnt == HALF_LAST);
            end
            S_DATA: begin
                led_rx   = 1'b1;
                bit_tick = (clk_cnt == BIT_LAST);
            end
            S_STOP: begin
                led_rx   = 1'b1;
                bit_tick = (clk_cnt == BIT_LAST);
                stop_ok  = bit_tick & rx_p1;
                stop_bad = bit_tick & ~rx_p1;
            end
            default: led_rx = 1'b0;
        endcase
    end

    // ---- bit timing and deserialiser ----------------------------------------
    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= '0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            unique case (state)
                S_IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= 3'd0;
                end
                S_START: begin
                    clk_cnt <= half_tick ? '0 : (clk_cnt + CNT_ONE);
                end
                S_DATA: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        // LSB arrives first, so shift in from the top.
                        shreg   <= {rx_p1, shreg[7:1]};
                    end else begin
                        clk_cnt <= clk_cnt + CNT_ONE;
                    end
                end
                S_STOP: begin
                    clk_cnt <= clk_cnt + CNT_ONE;
                end
                default: begin
                    clk_cnt <= '0;
                    bit_idx <= 3'd0;
                end
            endcase
        end
    end

    // ---- word assembly and memory write -------------------------------------
    assign load_rise = load_en & ~load_en_q;
`ifndef LOADER_END_MARKER_EN
    assign load_fall = ~load_en & load_en_q;
`endif
    assign word_nxt  = {data_q[15:8], shreg};

    always_ff @(posedge clk_100 or negedge rst_n) begin
        if (!rst_n) begin
            load_en_q  <= 1'b0;
            pending    <= 1'b0;
            addr_q     <= BASE_ADDR;
            data_q     <= 16'h0000;
            we_q       <= 1'b0;
            word_count <= 16'h0000;
            frame_err  <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            load_en_q <= load_en;
            we_q      <= 1'b0;

            // Address/count advance in the cycle after the strobe so both are
            // stable for the whole write cycle.
            if (we_q) begin
                addr_q <= addr_q + 16'd1;
                if (word_count != 16'hFFFF) begin
                    word_count <= word_count + 16'd1;
                end
            end

            if (load_rise) begin
                // Session restart wins over any byte completing this cycle.
                addr_q     <= BASE_ADDR;
                word_count <= 16'h0000;
                frame_err  <= 1'b0;
                load_done  <= 1'b0;
                pending    <= 1'b0;
            end else begin
`ifndef LOADER_END_MARKER_EN
                if (load_fall) begin
                    load_done <= 1'b1;
                end
`endif
                if (stop_bad) begin
                    frame_err <= 1'b1;
                    pending   <= 1'b0;
                end else if (stop_ok && load_en && !load_done) begin
                    if (!pending) begin
                        data_q[15:8] <= shreg;
                        pending      <= 1'b1;
                    end else begin
                        pending <= 1'b0;
`ifdef LOADER_END_MARKER_EN
                        if (word_nxt == 16'hFFFF) begin
                            load_done <= 1'b1;
                        end else begin
                            data_q[7:0] <= shreg;
                            we_q        <= 1'b1;
                        end
`else
                        data_q[7:0] <= shreg;
                        we_q        <= 1'b1;
`endif
                    end
                end

                // With loading disabled a half-word must not survive into
                // the next session.
                if (!load_en) begin
                    pending <= 1'b0;
                end
            end
        end
    end

    assign mem.addr_io    = addr_q;
    assign mem.data_in_io = data_q;
    assign mem.we_io      = we_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// -----------------------------------------------------------------------------
// tb_uart_word_loader
//   Directed + randomised bench for uart_word_loader. A byte-level reference
//   model predicts the list of memory writes and the status outputs; a monitor
//   records every we_io cycle seen on the memory port.
//   BASE_ADDR is set just below the top of the address space so the address
//   wrap is exercised by the first few writes.
// -----------------------------------------------------------------------------
module tb_uart_word_loader;

    localparam int          CPB  = 16;
    localparam logic [15:0] BASE = 16'hFFFE;
`ifdef LOADER_END_MARKER_EN
    localparam bit MARKER = 1'b1;
`else
    localparam bit MARKER = 1'b0;
`endif

    logic        clk_100 = 1'b0;
    logic        rst_n;
    logic        rx;
    logic        load_en;
    logic        led_rx;
    logic [15:0] word_count;
    logic        frame_err;
    logic        load_done;

    uart_word_loader_if mem_if ();

    uart_word_loader #(
        .CLKS_PER_BIT (CPB),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk_100    (clk_100),
        .rst_n      (rst_n),
        .rx         (rx),
        .load_en    (load_en),
        .mem        (mem_if),
        .led_rx     (led_rx),
        .word_count (word_count),
        .frame_err  (frame_err),
        .load_done  (load_done)
    );

    always #5 clk_100 = ~clk_100;

    int total = 0;
    int bad   = 0;

    // ---- monitor: record writes, flag back-to-back strobes ------------------
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int          b2b     = 0;
    logic        we_prev = 1'b0;

    always @(negedge clk_100) begin
        if (mem_if.we_io) begin
            obs_q.push_back({mem_if.addr_io, mem_if.data_in_io});
        end
        if (we_prev && mem_if.we_io) begin
            b2b <= b2b + 1;
        end
        we_prev <= mem_if.we_io;
    end

    // ---- reference model state ----------------------------------------------
    logic [15:0] m_addr;
    logic [15:0] m_count;
    logic        m_ferr;
    logic        m_done;
    logic        m_pend;
    logic [7:0]  m_hi;
    logic        m_en;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic model_session();
        m_addr  = BASE;
        m_count = 16'h0000;
        m_ferr  = 1'b0;
        m_done  = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        logic [15:0] w;
        if (!ok) begin
            m_ferr = 1'b1;
            m_pend = 1'b0;
        end else if (m_en && !m_done) begin
            if (!m_pend) begin
                m_hi   = b;
                m_pend = 1'b1;
            end else begin
                w      = {m_hi, b};
                m_pend = 1'b0;
                if (MARKER && (w == 16'hFFFF)) begin
                    m_done = 1'b1;
                end else begin
                    exp_q.push_back({m_addr, w});
                    m_addr = m_addr + 16'd1;
                    if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                end
            end
        end
    endtask

    task automatic idle_bits(input int n);
        repeat (n * CPB) @(negedge clk_100);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk_100);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_hi);
        @(negedge clk_100);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_hi);
        rx = 1'b1;
        idle_bits(2);
        model_byte(b, stop_hi);
    endtask

    task automatic set_load(input logic v);
        @(negedge clk_100);
        load_en = v;
        if (v && !m_en) model_session();
        if (!v && m_en) begin
            m_pend = 1'b0;
            if (!MARKER) m_done = 1'b1;
        end
        m_en = v;
        repeat (4) @(negedge clk_100);
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_nwrites"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_write"}, obs_q[i], exp_q[i]);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_addr"},  mem_if.addr_io, m_addr);
        chk({tag, "_count"}, word_count, m_count);
        chk({tag, "_ferr"},  frame_err, m_ferr);
        chk({tag, "_done"},  load_done, m_done);
        chk({tag, "_led"},   led_rx, 1'b0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"},  mem_if.addr_io, BASE);
        chk({tag, "_data"},  mem_if.data_in_io, 16'h0000);
        chk({tag, "_we"},    mem_if.we_io, 1'b0);
        chk({tag, "_led"},   led_rx, 1'b0);
        chk({tag, "_count"}, word_count, 16'h0000);
        chk({tag, "_ferr"},  frame_err, 1'b0);
        chk({tag, "_done"},  load_done, 1'b0);
    endtask

    initial begin
        int          led_cnt;
        logic [7:0]  rb;
        bit          rok;

        rx      = 1'b1;
        load_en = 1'b0;
        rst_n   = 1'b0;
        m_en    = 1'b0;
        model_session();

        // reset state
        repeat (3) @(negedge clk_100);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk_100);
        check_reset_vals("after_reset");

        // basic pair
        set_load(1'b1);
        send_frame(8'hE8, 1'b1);
        send_frame(8'h12, 1'b1);
        check_writes("pair");
        check_state("pair");

        // all-ones word: end marker or ordinary word (wraps the address)
        send_frame(8'hFF, 1'b1);
        send_frame(8'hFF, 1'b1);
        check_writes("ffff");
        check_state("ffff");
        set_load(1'b0);
        check_state("ffff_fall");

        // framing error discards byte, later pair still lands at BASE
        set_load(1'b1);
        send_frame(8'hA5, 1'b0);
        check_state("ferr");
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_writes("ferr_pair");
        check_state("ferr_pair");

        // short low glitch: brief led_rx pulse, nothing else
        @(negedge clk_100);
        rx = 1'b0;
        repeat (3) @(negedge clk_100);
        rx = 1'b1;
        led_cnt = 0;
        for (int i = 0; i < 3 * CPB; i++) begin
            @(negedge clk_100);
            if (led_rx) led_cnt++;
        end
        chk("glitch_led_seen", (led_cnt > 0), 1'b1);
        chk("glitch_led_len", (led_cnt <= CPB / 2 + 3), 1'b1);
        check_writes("glitch");
        check_state("glitch");

        // load_en toggled with a half-word pending
        send_frame(8'h77, 1'b1);
        set_load(1'b0);
        check_state("toggle_low");
        set_load(1'b1);
        send_frame(8'h34, 1'b1);
        send_frame(8'h56, 1'b1);
        check_writes("toggle");
        check_state("toggle");

        // randomised bytes, mostly good stop bits
        for (int i = 0; i < 10; i++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 5) != 0);
            send_frame(rb, rok);
        end
        check_writes("random");
        check_state("random");

        // reset during the data bits of the second byte
        set_load(1'b0);
        set_load(1'b1);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        @(negedge clk_100);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        chk("midframe_led", led_rx, 1'b1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midframe_reset");
        model_session();
        repeat (3) @(negedge clk_100);
        rst_n = 1'b1;
        idle_bits(12);
        check_writes("midframe_none");
        rb = 8'($urandom_range(0, 254));
        send_frame(8'h9C, 1'b1);
        send_frame(rb, 1'b1);
        check_writes("after_reset_pair");
        check_state("after_reset_pair");

        // loading disabled: frames received, nothing written
        set_load(1'b0);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        check_writes("disabled");
        check_state("disabled");

        chk("no_back_to_back_we", b2b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

UART receive-and-load stage feeding the block RAM ahead of the processor. Deserialises 8N1 frames on `rx`, pairs consecutive bytes into 16-bit words and writes them to sequential memory addresses on the I/O port (`addr_io`/`data_in_io`/`we_io`). It is active only while loading is enabled, i.e. while the load switch is high. The processor is released only after the load completes.

## Interface
- `CLKS_PER_BIT`, 868, clk_100 cycles per bit (115200 baud at 100 MHz); must be ≥ 4.
- `BASE_ADDR`, 16'h0000, first write address of each load session.
- `clk_100`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  UART line, idle high, asynchronous to `clk_100`.
- `load_en`  in  1  load session enable (level); rising edge starts a new session.
- `addr_io`  out  16  memory write address.
- `data_in_io`  out  16  memory write data.
- `we_io`  out  1  one-cycle write strobe.
- `led_rx`  out  1  high while a frame is being received.
- `word_count`  out  16  words written in the current session.
- `frame_err`  out  1  sticky: a stop bit sampled low this session.
- `load_done`  out  1  session complete (see Configuration).

## Operation
- `rx` passes through a 2-flop synchroniser; all decisions use the synchronised value.
- Receiver FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: waits for a synchronised falling edge; enters START with the bit counter cleared.
  - START: at CLKS_PER_BIT/2 re-samples the line.
    - Low: enters DATA.
    - High: glitch; returns to IDLE.
  - DATA: samples 8 bits, LSB first, every CLKS_PER_BIT.
  - STOP: samples once at CLKS_PER_BIT after the last data bit.
    - High: byte valid.
    - Low: sets `frame_err`, discards the byte, clears any pending half-word.
    - Either way: returns to IDLE immediately after the sample. There is no wait for the end of the stop bit.
- `led_rx` = 1 in START, DATA and STOP.
- Word assembly, applied to valid bytes only when `load_en`=1 and `load_done`=0:
  - First byte → `data_in_io[15:8]`; sets the pending flag.
  - Second byte → `data_in_io[7:0]`; clears the pending flag and triggers a write.
- Write: `we_io` is high for exactly one cycle with `addr_io` and `data_in_io` stable.
  - On the following cycle `addr_io` increments by 1 and `word_count` increments by 1.
  - `addr_io` wraps 16'hFFFF → 16'h0000; `word_count` saturates at 16'hFFFF.
- Rising edge of `load_en`:
  - `addr_io` ← BASE_ADDR.
  - `word_count`, `frame_err`, `load_done` and the pending flag cleared.
  - A frame in progress continues to be received.
- `load_en`=0: frames are still received (`led_rx` toggles) but bytes are discarded and the pending flag is cleared. No writes occur.

## Timing
- Reset values:
  - `addr_io` = BASE_ADDR.
  - `data_in_io`, `we_io`, `led_rx`, `word_count`, `frame_err`, `load_done` = 0.
  - FSM in IDLE.
- Reset asserted mid-frame or mid-write: all state is aborted immediately, with no spurious `we_io`.
- Start edge detection: 2–3 cycles after the `rx` falling edge (synchroniser latency).
- Second-byte stop-bit sample → `we_io` high on the next cycle.
- `addr_io`/`word_count` update one cycle after `we_io`.
- Minimum spacing between writes is one full word (20 bit times), so there is never back-to-back `we_io`.
- `load_en` rising edge in the same cycle as a byte-valid event: the session reset wins and the byte is discarded.

## Configuration
- `LOADER_END_MARKER_EN` defined:
  - An assembled word 16'hFFFF is not written.
  - Instead `load_done` is set (sticky) the cycle it would have been written.
  - Subsequent bytes are ignored until the next `load_en` rising edge.
- Not defined:
  - 16'hFFFF is written like any other word.
  - `load_done` is set on the falling edge of `load_en`, and cleared by the next rising edge.

## Test plan
- Use CLKS_PER_BIT=16 for speed, plus one run at 868.
- Session with bytes 0xE8, 0x12 after a `load_en` rise → one `we_io` pulse with `addr_io`=0x0000, `data_in_io`=0xE812; then `addr_io`=0x0001 and `word_count`=1.
- Bytes 0xE8, 0x12, 0xFF, 0xFF with `LOADER_END_MARKER_EN` → exactly one write, then `load_done`=1. The same stimulus without the macro → second write of 0xFFFF at 0x0001, and `load_done` rises only when `load_en` falls.
- Byte 0xA5 with its stop bit held low, then 0x11, 0x22 → `frame_err`=1, no write for 0xA5, then one write of 0x1122 at 0x0000.
- Low glitch on `rx` of 3 cycles → FSM returns to IDLE, `led_rx` pulses for at most CLKS_PER_BIT/2+3 cycles, no byte and no error.
- `rst_n` pulsed low during the DATA state of the second byte → all outputs return to reset values immediately; the next full pair is written at BASE_ADDR.
- `load_en` dropped after one byte and raised again, then 0x34, 0x56 → pending byte discarded, single write of 0x3456 at BASE_ADDR, `word_count`=1.
